// File: rtl/program_counter_ctrl.sv
// ---------------------------------------------------------------------------
// program_counter_ctrl
//
// Fetch-stage program counter control. Holds the current fetch PC and
// decides each cycle whether it advances by 4, is redirected (trap or
// branch/jump), or holds. A small BOOT/RUN/HALT state machine gates the
// fetch request, and an accepted-fetch counter tracks completed handshakes.
//
// Optional feature (compile-time macro PC_MISALIGN_TRAP_EN):
//   defined   : a branch target with non-zero low ALIGN_BITS bits is turned
//               into a trap to TRAP_VECTOR and Misalign_Err pulses.
//   undefined : the low ALIGN_BITS bits of the target are cleared and the
//               branch proceeds normally; Misalign_Err is tied low.
//
// Ports:
//   Clk_Core           in   core clock, rising edge
//   Rst_Core           in   asynchronous active-high reset
//   PC_Sel             in   1 = load Program_Count_Imm
//   Program_Count_Imm  in   branch/jump target  [DWIDTH]
//   Trap_Req           in   redirect to TRAP_VECTOR (highest priority)
//   Stall              in   hold PC, block sequential advance
//   Halt_Req           in   enter HALT
//   Resume             in   leave HALT
//   Fetch_Ready        in   instruction memory accepts current address
//   Fetch_Valid        out  Program_Count is a valid fetch request
//   Program_Count      out  current fetch PC (registered) [DWIDTH]
//   Program_Count_Off  out  Program_Count + 4, wrapping [DWIDTH]
//   Flush              out  redirect taken this cycle
//   Misalign_Err       out  misaligned branch target trapped this cycle
//   Halted             out  high while in HALT
//   Fetch_Count        out  accepted fetch count, wrapping [CWIDTH]
// ---------------------------------------------------------------------------
module program_counter_ctrl #(
  parameter int                 DWIDTH       = 32,
  parameter logic [DWIDTH-1:0]  RESET_VECTOR = DWIDTH'(32'h0000_0000),
  parameter logic [DWIDTH-1:0]  TRAP_VECTOR  = DWIDTH'(32'h0000_0100),
  parameter int                 ALIGN_BITS   = 2,
  parameter int                 CWIDTH       = 32
) (
  input  logic              Clk_Core,
  input  logic              Rst_Core,
  input  logic              PC_Sel,
  input  logic [DWIDTH-1:0] Program_Count_Imm,
  input  logic              Trap_Req,
  input  logic              Stall,
  input  logic              Halt_Req,
  input  logic              Resume,
  input  logic              Fetch_Ready,
  output logic              Fetch_Valid,
  output logic [DWIDTH-1:0] Program_Count,
  output logic [DWIDTH-1:0] Program_Count_Off,
  output logic              Flush,
  output logic              Misalign_Err,
  output logic              Halted,
  output logic [CWIDTH-1:0] Fetch_Count
);

  // Mask of the low PC bits that must be zero for an aligned instruction.
  // Built through a wide shift so ALIGN_BITS = 0 yields an all-zero mask.
  localparam logic [DWIDTH-1:0] ALIGN_MASK =
    DWIDTH'((64'd1 << ALIGN_BITS) - 64'd1);

  localparam logic [DWIDTH-1:0] PC_STEP  = DWIDTH'(4);
  localparam logic [CWIDTH-1:0] CNT_STEP = CWIDTH'(1);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [DWIDTH-1:0]   pc_q, pc_d;
  logic [CWIDTH-1:0]   cnt_q, cnt_d;

  logic                fetch_valid_s;
  logic                accept_s;
  logic                active_s;
  logic                flush_s;
  logic                misalign_s;
  logic [DWIDTH-1:0]   pc_inc_s;

  // State, PC and fetch counter registers.
  always_ff @(posedge Clk_Core or posedge Rst_Core) begin
    if (Rst_Core) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_VECTOR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  // Handshake qualifiers derived from the current state.
  always_comb begin
    fetch_valid_s = 1'b0;
    active_s      = 1'b0;
    accept_s      = 1'b0;
    pc_inc_s      = pc_q + PC_STEP;
    // Only RUN issues fetches; redirects are honoured outside BOOT.
    if (state_q == ST_RUN) begin
      fetch_valid_s = 1'b1;
    end else begin
      fetch_valid_s = 1'b0;
    end
    if (state_q != ST_BOOT) begin
      active_s = 1'b1;
    end else begin
      active_s = 1'b0;
    end
    accept_s = fetch_valid_s & Fetch_Ready & ~Stall;
  end

  // Next-PC selection: trap, then branch, then sequential advance, else hold.
  // While the request is not accepted (backpressure or stall) the PC only
  // moves on a redirect, which keeps the presented address stable.
  always_comb begin
    pc_d       = pc_q;
    flush_s    = 1'b0;
    misalign_s = 1'b0;
    if (active_s && Trap_Req) begin
      pc_d    = TRAP_VECTOR;
      flush_s = 1'b1;
    end else if (active_s && PC_Sel) begin
      flush_s = 1'b1;
`ifdef PC_MISALIGN_TRAP_EN
      if ((Program_Count_Imm & ALIGN_MASK) != '0) begin
        // Misaligned target becomes a trap instead of a bad fetch.
        pc_d       = TRAP_VECTOR;
        misalign_s = 1'b1;
      end else begin
        pc_d       = Program_Count_Imm;
        misalign_s = 1'b0;
      end
`else
      // Low bits are silently cleared so fetch stays aligned.
      pc_d       = Program_Count_Imm & ~ALIGN_MASK;
      misalign_s = 1'b0;
`endif
    end else if (accept_s) begin
      pc_d = pc_inc_s;
    end else begin
      pc_d = pc_q;
    end
  end

  // Accepted-fetch counter; a redirect in the same cycle still counts.
  always_comb begin
    cnt_d = cnt_q;
    if (accept_s) begin
      cnt_d = cnt_q + CNT_STEP;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // BOOT/RUN/HALT transitions. Halt_Req dominates Resume; redirects never
  // change the state by themselves.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_BOOT: begin
        if (Halt_Req) begin
          state_d = ST_HALT;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (Halt_Req) begin
          state_d = ST_HALT;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_HALT: begin
        if (Halt_Req) begin
          state_d = ST_HALT;
        end else if (Resume) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_HALT;
        end
      end
      default: begin
        // Unreachable encoding: restart through BOOT.
        state_d = ST_BOOT;
      end
    endcase
  end

  // Output mapping. Flush and Misalign_Err react in the cycle the redirect
  // is sampled; the rest are decoded directly from registers.
  always_comb begin
    Fetch_Valid       = fetch_valid_s;
    Halted            = (state_q == ST_HALT);
    Program_Count     = pc_q;
    Program_Count_Off = pc_inc_s;
    Flush             = flush_s;
    Misalign_Err      = misalign_s;
    Fetch_Count       = cnt_q;
  end

endmodule

// File: doc/program_counter_ctrl.md
Name: program_counter_ctrl

Overview:
Parametrised PC control unit for the fetch stage.
- Adds a fetch handshake, stall/halt control, trap redirect, alignment checking and an accepted-fetch counter to basic PC+4/branch-select behaviour.
- Sits between the control/branch unit and instruction memory, and drives the fetch address and PC+4 link value.

Parameters:
- DWIDTH, 32, PC/address width.
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
- TRAP_VECTOR, 32'h0000_0100, PC value loaded on a trap request.
- ALIGN_BITS, 2, low PC bits that must be zero (2 = word-aligned instructions).
- CWIDTH, 32, width of the accepted-fetch counter.

Ports:
- Clk_Core  in  1  core clock; all state changes on the rising edge.
- Rst_Core  in  1  asynchronous, active-high reset.
- PC_Sel  in  1  branch/jump taken: 0 = sequential, 1 = load Program_Count_Imm.
- Program_Count_Imm  in  DWIDTH  branch/jump target.
- Trap_Req  in  1  trap/exception request: redirect to TRAP_VECTOR.
- Stall  in  1  pipeline stall: hold PC, no sequential advance.
- Halt_Req  in  1  enter HALT state.
- Resume  in  1  leave HALT state.
- Fetch_Ready  in  1  instruction memory accepts the current address.
- Fetch_Valid  out  1  Program_Count is a valid fetch request.
- Program_Count  out  DWIDTH  current fetch PC (registered).
- Program_Count_Off  out  DWIDTH  Program_Count + 4, combinational, wraps modulo 2^DWIDTH.
- Flush  out  1  one-cycle pulse: a redirect was taken, so younger fetches are discarded.
- Misalign_Err  out  1  one-cycle pulse: misaligned branch target (only with the optional feature).
- Halted  out  1  high while in HALT.
- Fetch_Count  out  CWIDTH  number of accepted fetches.

Behaviour:
Reset values:
- While Rst_Core is high: Program_Count = RESET_VECTOR, state = BOOT.
- Fetch_Valid = 0, Flush = 0, Misalign_Err = 0, Halted = 0, Fetch_Count = 0.
- A reset asserted mid-operation overrides everything, with immediate (asynchronous) effect.

States:
- BOOT: one cycle after reset deasserts, with Fetch_Valid = 0. Next state is RUN, or HALT if Halt_Req is high.
- RUN: Fetch_Valid = 1.
- HALT: Fetch_Valid = 0, Halted = 1. Returns to RUN on the cycle after Resume is sampled high. If Halt_Req and Resume are both high, Halt_Req wins and the block stays in HALT.

Accept condition:
- accept = Fetch_Valid & Fetch_Ready & ~Stall.
- On accept, Fetch_Count increments by 1 and wraps at 2^CWIDTH.

Next-PC priority, evaluated each cycle, highest first:
1. Trap_Req: PC <= TRAP_VECTOR, Flush = 1.
2. PC_Sel: PC <= target, Flush = 1.
3. accept: PC <= PC + 4.
4. Otherwise PC holds.

Redirect rules:
- Redirects (priorities 1–2) are taken in any state, including HALT (PC updates, state unchanged) and while Stall or ~Fetch_Ready.
- Redirects are ignored during BOOT.

Handshake rules:
- While Fetch_Valid & ~Fetch_Ready, Program_Count must remain stable unless a redirect occurs.
- A redirect in the same cycle as accept still counts the fetch, but the PC takes the redirect value.

Latency and timing:
- A new PC appears one cycle after the input that selected it.
- Flush is asserted combinationally in the cycle the redirect is sampled, and is never asserted in BOOT.

Arithmetic:
- PC + 4 wraps: 32'hFFFF_FFFC advances to 32'h0000_0000 with no error.

Optional Feature:
Macro: PC_MISALIGN_TRAP_EN
- Defined: if PC_Sel = 1 and the target's low ALIGN_BITS bits are non-zero (and Trap_Req = 0), PC <= TRAP_VECTOR, Flush = 1 and Misalign_Err pulses for one cycle.
- Not defined: the target's low ALIGN_BITS bits are forced to zero, the redirect proceeds normally, and Misalign_Err is tied to 0.

Test Plan:
1. Reset and boot: hold Rst_Core high 3 cycles, then release with Fetch_Ready = 1 → PC = 0x0 throughout BOOT with Fetch_Valid = 0, then RUN. PC sequence 0x0, 0x4, 0x8. Fetch_Count = 2 after the second accept. Program_Count_Off = 0x4 at PC = 0x0.
2. Backpressure and stall: at PC = 0x10, drop Fetch_Ready 3 cycles, then assert Stall 2 cycles with Fetch_Ready = 1 → PC holds 0x10 for all 5 cycles and Fetch_Count holds. PC = 0x14 on the cycle after Stall drops.
3. Priority: at PC = 0x20, assert Trap_Req and PC_Sel together with Program_Count_Imm = 0x400 → next PC = 0x100 and Flush pulses once. PC_Sel alone with 0x400 → next PC = 0x400 and Flush pulses once.
4. Halt/resume: Halt_Req at PC = 0x8 → Halted = 1, Fetch_Valid = 0, PC frozen. PC_Sel to 0x200 while halted → PC = 0x200 and state stays HALT. Resume → RUN, fetch starts at 0x200.
5. Wrap and async reset: from PC = 0xFFFF_FFFC with accept → PC = 0x0. Assert Rst_Core mid-RUN between clock edges → PC = RESET_VECTOR and Fetch_Valid = 0 immediately.
6. Misaligned target (0x402):
   - With PC_MISALIGN_TRAP_EN: next PC = 0x100, Misalign_Err and Flush pulse.
   - Without it: next PC = 0x400, Misalign_Err stays 0.
